fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Parametrised instruction-fetch stage for the pipelined MIPS core: owns the PC and issues
//   requests to instruction memory with a req/gnt/rvalid handshake and variable latency.
// - Buffers fetched words in a small prefetch queue and presents them to ID as the IF/ID register.
// - Takes branch/jump redirects (flush) and hazard stalls from ID.
// PARAMETERS
// - ADDR_W     32  PC / memory address width
// - INST_W     32  instruction word width
// - RESET_PC   0   PC after reset; bits [1:0] forced to 0
// - BUF_DEPTH  2   prefetch queue entries; power of 2, >= 2
// PORTS
// - clock            in   1       single clock, rising edge
// - reset            in   1       asynchronous, active-high
// - imem_req         out  1       fetch request valid
// - imem_addr        out  ADDR_W  word-aligned fetch address
// - imem_gnt         in   1       request accepted this cycle
// - imem_rvalid      in   1       read data valid; earliest 1 cycle after gnt
// - imem_rdata       in   INST_W  instruction word
// - redirect_valid   in   1       branch taken or jump resolved in ID
// - redirect_target  in   ADDR_W  new PC; bits [1:0] ignored
// - stall            in   1       hazard: hold the IF/ID output (the inverse of IFIDWrite)
// - if_valid         out  1       IF/ID holds a valid instruction
// - if_pc            out  ADDR_W  PC of the presented instruction
// - if_pc_plus4      out  ADDR_W  if_pc + 4, modulo 2^ADDR_W
// - if_inst          out  INST_W  presented instruction
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, state=FETCH, queue empty; imem_req=0, if_valid=0, if_pc=0, if_inst=0.
// - At most one request outstanding. States:
//   FETCH: imem_req=1 iff queue count < BUF_DEPTH (slot reserved); imem_addr=pc.
//          On gnt: req_pc<=pc, pc<=pc+4 (wraps), ->WAIT.
//   WAIT:  imem_req=0. On rvalid: push {req_pc, rdata}, ->FETCH.
//   DROP:  imem_req=0. On rvalid: discard data, ->FETCH.
// - Queue head drives if_valid/if_pc/if_inst. All are 0 when the queue is empty.
// - Pop when if_valid && !stall && !redirect_valid. With stall=1 the outputs hold stable.
// - Push and pop in the same cycle are allowed. Count stays the same.
// - redirect_valid has priority over stall, gnt and rvalid:
//   - Flush the queue, so if_valid=0 next cycle.
//   - Set pc <= {redirect_target[ADDR_W-1:2], 2'b00}.
//   - FETCH with gnt in the same cycle -> DROP. WAIT -> DROP, or FETCH if rvalid arrives in the
//     same cycle (data discarded). DROP stays DROP.
//   - Request to the target issues in the next cycle if the state is FETCH, otherwise after the
//     stale response.
// - Redirect latency: redirect at cycle t -> imem_req with target at t+1 (best case). The target
//   instruction reaches if_valid at gnt + mem latency + 1.
// - Throughput: one instruction per 2 cycles minimum (gnt, then rvalid); the queue hides ID stalls.
// - pc+4 overflow wraps silently. imem_rvalid outside WAIT/DROP is a protocol error:
//   assert in simulation, ignore in RTL.
// - Reset mid-request: state and queue clear at once, and any later rvalid is ignored
//   (state FETCH, no outstanding request).
// STRUCTURE
// - cpu_pkg: ADDR_W/INST_W defaults, INST_BYTES=4, fetch_state_t enum {FETCH, WAIT, DROP},
//   fetch_entry_t {pc, inst}.
// - Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t, depth BUF_DEPTH, with push, pop,
//   flush, count and first-word-fall-through head.
// - The top level holds the PC register, the FSM, req_pc and the output zeroing.
// TESTING
// - Reset with RESET_PC=0x100, gnt=1, 1-cycle rvalid -> addresses 0x100, 0x104, 0x108;
//   if_pc_plus4=0x104 for the first instruction.
// - Hold stall=1 for 10 cycles -> the queue fills to 2, imem_req drops to 0 and if_pc/if_inst hold.
//   After release: in-order pops with no loss or duplicates.
// - Redirect to 0x2000 while in WAIT -> the next rvalid is discarded, then a request to 0x2000 issues.
//   Observed if_pc sequence: 0x2000, 0x2004.
// - Redirect and stall in the same cycle with a full queue -> the queue flushes, if_valid=0 next
//   cycle, fetch restarts at the target.
// - Redirect_target=0x3003 -> imem_addr=0x3000. pc=0xFFFFFFFC -> next imem_addr=0x00000000.
// - Assert reset between gnt and rvalid -> outputs 0 immediately. A late rvalid is ignored and the
//   first post-reset fetch goes to RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the MIPS core front end.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO between instruction memory and ID: first-word-fall-through head,
// synchronous flush. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wdata,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != FULL);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the top level masks the head while the queue is empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding req/gnt/rvalid fetch FSM,
// and the IF/ID view of the prefetch queue head.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                INST_W    = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              stall,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [INST_W-1:0] if_inst,
  output logic [1:0]        dbg_state
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam int                CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              push, pop, granted;
  entry_t            head, wdata;
  logic [CNT_W-1:0]  count;
  logic              unused_tgt_bits;

  assign unused_tgt_bits = ^redirect_target[1:0];

  // A request is only raised when a queue slot is free, so every response has a home.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    granted  = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = !reset && (count < FULL);
        granted  = imem_req && imem_gnt;
        if (granted) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + STEP;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Redirect wins: any in-flight or just-granted request becomes stale and is dropped.
    if (redirect_valid) begin
      push = 1'b0;
      pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
      if (state_q == FETCH) state_d = granted ? DROP : FETCH;
      else                  state_d = imem_rvalid ? FETCH : DROP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign wdata = {req_pc_q, imem_rdata};
  assign pop   = if_valid && !stall && !redirect_valid;

  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign if_valid    = (count != '0);
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_inst     = if_valid ? head.inst : '0;
  assign if_pc_plus4 = if_valid ? head.pc + STEP : '0;
  assign imem_addr   = pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory responder
// and an in-order scoreboard of expected presented PCs.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_inst;
  logic [1:0]  dbg_state;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  bit          gnt_rand = 1'b0;
  bit          lat_rand = 1'b0;
  bit          allow_stray = 1'b0;
  int          lat = 1;
  bit          pending = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;

  fetch_unit #(
    .ADDR_W    (32),
    .INST_W    (32),
    .RESET_PC  (32'h100),
    .BUF_DEPTH (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_inst         (if_inst),
    .dbg_state       (dbg_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: one outstanding request, rvalid `lat` cycles after the grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clock);
      #2;
      imem_rvalid = 1'b0;
      if (pending) begin
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = inst_of(pend_addr);
          pending     = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      imem_gnt = !pending && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (imem_req && imem_gnt) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        lat_cnt   = (lat_rand ? int'($urandom_range(1, 3)) : lat) - 1;
        addr_log.push_back(imem_addr);
      end
    end
  end

  // Protocol monitor: a response must only arrive while a request is outstanding.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (imem_rvalid && !allow_stray) begin
        checks++;
        assert (dbg_state != 2'(FETCH)) else begin
          errors++;
          $error("FAIL rvalid_state: observed state=%0d expected WAIT or DROP", dbg_state);
        end
      end
    end
  end

  // Driver: one cycle of ID-side inputs; scoreboard compare whenever ID consumes.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clock);
    stall           = st;
    redirect_valid  = rd;
    redirect_target = tgt;
    #1;
    if (if_valid && !st && !rd) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed if_pc=%h expected empty queue", if_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", if_pc, e);
        chk("pop_inst", if_inst, inst_of(e));
        chk("pop_pc_plus4", if_pc_plus4, e + 32'd4);
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input bit st);
    step(st, 1'b1, tgt);
    #2;
    exp_q.delete();
    addr_log.delete();
  endtask

  task automatic drain(input int max, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step(rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0, '0);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("boot_req", 32'(imem_req), 1);
    chk("boot_addr", imem_addr, 32'h100);

    // Sequential fetch from RESET_PC
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    drain(40, 1'b0);
    chk("seq_addr0", addr_log[0], 32'h100);
    chk("seq_addr1", addr_log[1], 32'h104);
    chk("seq_addr2", addr_log[2], 32'h108);

    // Stall fills the queue and holds IF/ID
    redirect_to(32'h400, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h400 + 32'(4 * i));
    repeat (10) step(1'b1, 1'b0, '0);
    chk("stall_valid", 32'(if_valid), 1);
    chk("stall_req", 32'(imem_req), 0);
    chk("stall_pc", if_pc, 32'h400);
    chk("stall_inst", if_inst, inst_of(32'h400));
    drain(40, 1'b0);

    // Redirect while WAIT: stale response dropped
    lat = 3;
    redirect_to(32'h600, 1'b1);
    for (int i = 0; i < 40 && dbg_state != 2'(WAIT); i++) step(1'b1, 1'b0, '0);
    chk("reach_wait", 32'(dbg_state), 32'(WAIT));
    redirect_to(32'h2000, 1'b1);
    step(1'b1, 1'b0, '0);
    chk("drop_state", 32'(dbg_state), 32'(DROP));
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    drain(60, 1'b0);
    chk("redir_addr", addr_log[0], 32'h2000);

    // Redirect + stall with a full queue
    lat = 1;
    redirect_to(32'hA00, 1'b1);
    repeat (8) step(1'b1, 1'b0, '0);
    chk("full_valid", 32'(if_valid), 1);
    chk("full_req", 32'(imem_req), 0);
    redirect_to(32'hB00, 1'b1);
    exp_q.push_back(32'hB00);
    exp_q.push_back(32'hB04);
    step(1'b1, 1'b0, '0);
    chk("flush_valid", 32'(if_valid), 0);
    drain(40, 1'b0);
    chk("flush_addr", addr_log[0], 32'hB00);

    // Unaligned target and PC wrap
    lat = 2;
    redirect_to(32'h3003, 1'b0);
    exp_q.push_back(32'h3000);
    step(1'b0, 1'b0, '0);
    chk("align_addr", imem_addr, 32'h3000);
    drain(40, 1'b0);
    chk("align_log", addr_log[0], 32'h3000);
    redirect_to(32'hFFFF_FFFC, 1'b0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    drain(40, 1'b0);
    chk("wrap_addr0", addr_log[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", addr_log[1], 32'h0000_0000);

    // Randomised grant, latency and stall
    gnt_rand = 1'b1;
    lat_rand = 1'b1;
    redirect_to(32'h800, 1'b0);
    for (int i = 0; i < 30; i++) exp_q.push_back(32'h800 + 32'(4 * i));
    drain(900, 1'b1);
    gnt_rand = 1'b0;
    lat_rand = 1'b0;

    // Reset between gnt and rvalid
    lat = 4;
    redirect_to(32'h700, 1'b1);
    for (int i = 0; i < 60 && !(dbg_state == 2'(WAIT) && if_valid); i++) step(1'b1, 1'b0, '0);
    chk("pre_rst_wait", 32'(dbg_state), 32'(WAIT));
    chk("pre_rst_valid", 32'(if_valid), 1);
    @(negedge clock);
    #2;
    allow_stray = 1'b1;
    reset       = 1'b1;
    #1;
    chk("midrst_req", 32'(imem_req), 0);
    chk("midrst_valid", 32'(if_valid), 0);
    chk("midrst_pc", if_pc, 0);
    chk("midrst_inst", if_inst, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    exp_q.delete();
    addr_log.delete();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    drain(80, 1'b0);
    chk("postrst_addr", addr_log[0], 32'h100);
    allow_stray = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
